relu_out_packer: RTL

//  Sits directly downstream of the pool/ReLU stage and consumes its output stream.

---
 rtl/relu_out_packer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/relu_out_packer.sv
// Requantizes post-ReLU values to OUT_WID bits and packs LANES of them per word.
// Packed words go through a show-ahead FIFO, each tagged with its feature-map SRAM word address.
module relu_out_packer #(
  parameter int DATA_WID   = 16,
  parameter int OUT_WID    = 8,
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_WID   = 10
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    cfg_shift,
  input  logic [ADDR_WID-1:0]           cfg_base_addr,
  input  logic                          start,
  input  logic                          in_valid,
  input  logic [DATA_WID-1:0]           in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*OUT_WID-1:0]      out_data,
  output logic [ADDR_WID-1:0]           out_addr,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = LANES * OUT_WID;

  // Rounding right shift at DATA_WID+1 bits so the rounding add never wraps.
  function automatic logic [OUT_WID-1:0] requant(input logic [DATA_WID-1:0] v,
                                                 input logic [3:0]          sh);
    logic [DATA_WID:0]   rnd;
    logic [DATA_WID:0]   sum;
    logic [DATA_WID:0]   r;
    logic [OUT_WID-1:0]  res;
    if (sh == 4'd0) begin
      rnd = '0;
    end else begin
      rnd = {{DATA_WID{1'b0}}, 1'b1} << (sh - 4'd1);
    end
    sum = {1'b0, v} + rnd;
    r   = sum >> sh;
    if (v[DATA_WID-1]) begin
      res = '0;
    end else if (r > {{(DATA_WID+1-OUT_WID){1'b0}}, {OUT_WID{1'b1}}}) begin
      res = '1;
    end else begin
      res = r[OUT_WID-1:0];
    end
    return res;
  endfunction

  logic [LANE_W-1:0]   lane_idx_q, lane_idx_d;
  logic [WORD_W-1:0]   partial_q, partial_d;
  logic [ADDR_WID-1:0] addr_q, addr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [WORD_W-1:0]   mem_data_q [FIFO_DEPTH];
  logic [WORD_W-1:0]   mem_data_d [FIFO_DEPTH];
  logic [ADDR_WID-1:0] mem_addr_q [FIFO_DEPTH];
  logic [ADDR_WID-1:0] mem_addr_d [FIFO_DEPTH];
  logic                mem_last_q [FIFO_DEPTH];
  logic                mem_last_d [FIFO_DEPTH];

  logic [OUT_WID-1:0]  q_s;
  logic [LANE_W-1:0]   lane_eff_s;
  logic [WORD_W-1:0]   word_s;
  logic [ADDR_WID-1:0] addr_eff_s;
  logic                complete_s;
  logic                push_s;
  logic [PTR_W-1:0]    wr_eff_s;
  logic [PTR_W-1:0]    rd_eff_s;
  logic [CNT_W-1:0]    cnt_eff_s;
  logic                full_s;
  logic                pop_s;
  logic                push_ok_s;
  logic                drop_s;

  // start acts as an implicit flush before this cycle's input is folded in.
  always_comb begin
    q_s        = requant(in_data, cfg_shift);
    lane_eff_s = start ? '0 : lane_idx_q;
    addr_eff_s = start ? cfg_base_addr : addr_q;
    word_s     = start ? '0 : partial_q;
    for (int i = 0; i < LANES; i++) begin
      if (lane_eff_s == LANE_W'(i)) begin
        word_s[i*OUT_WID +: OUT_WID] = q_s;
      end else begin
        word_s[i*OUT_WID +: OUT_WID] = word_s[i*OUT_WID +: OUT_WID];
      end
    end
    complete_s = (lane_eff_s == LANE_W'(LANES - 1)) || in_last;
    push_s     = in_valid && complete_s;

    lane_idx_d = lane_eff_s;
    partial_d  = start ? '0 : partial_q;
    addr_d     = addr_eff_s;
    if (in_valid && complete_s) begin
      lane_idx_d = '0;
      partial_d  = '0;
      addr_d     = addr_eff_s + ADDR_WID'(1);
    end else if (in_valid) begin
      lane_idx_d = lane_eff_s + LANE_W'(1);
      partial_d  = word_s;
    end else begin
      lane_idx_d = lane_eff_s;
    end
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the head pops this cycle.
  always_comb begin
    wr_eff_s   = start ? '0 : wr_ptr_q;
    rd_eff_s   = start ? '0 : rd_ptr_q;
    cnt_eff_s  = start ? '0 : count_q;
    full_s     = (cnt_eff_s == CNT_W'(FIFO_DEPTH));
    pop_s      = out_valid && out_ready && !start;
    push_ok_s  = push_s && (!full_s || pop_s);
    drop_s     = push_s && full_s && !pop_s;

    mem_data_d = mem_data_q;
    mem_addr_d = mem_addr_q;
    mem_last_d = mem_last_q;
    if (push_ok_s) begin
      mem_data_d[wr_eff_s] = word_s;
      mem_addr_d[wr_eff_s] = addr_eff_s;
      mem_last_d[wr_eff_s] = in_last;
      wr_ptr_d             = wr_eff_s + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_eff_s;
    end

    if (pop_s) begin
      rd_ptr_d = rd_eff_s + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_eff_s;
    end

    if (push_ok_s && !pop_s) begin
      count_d = cnt_eff_s + CNT_W'(1);
    end else if (pop_s && !push_ok_s) begin
      count_d = cnt_eff_s - CNT_W'(1);
    end else begin
      count_d = cnt_eff_s;
    end

    if (drop_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = start ? 1'b0 : overflow_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lane_idx_q <= '0;
      partial_q  <= '0;
      addr_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_addr_q[i] <= '0;
        mem_last_q[i] <= 1'b0;
      end
    end else begin
      lane_idx_q <= lane_idx_d;
      partial_q  <= partial_d;
      addr_q     <= addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      mem_data_q <= mem_data_d;
      mem_addr_q <= mem_addr_d;
      mem_last_q <= mem_last_d;
    end
  end

  // Head entry is shown directly from storage and forced to zero when empty.
  always_comb begin
    out_valid  = (count_q != '0);
    fifo_count = count_q;
    overflow   = overflow_q;
    if (out_valid) begin
      out_data = mem_data_q[rd_ptr_q];
      out_addr = mem_addr_q[rd_ptr_q];
      out_last = mem_last_q[rd_ptr_q];
    end else begin
      out_data = '0;
      out_addr = '0;
      out_last = 1'b0;
    end
  end

endmodule
